rfsoc_cfg_serializer: RTL and testbench

- Hardware transmitter for the rfsoc_config GPIO serial-configuration protocol. Lets PL logic load config registers without PS software bit-banging.
- Accepts parallel register writes on a valid/ready handshake. Shifts each value out LSB-first on gpio_ctrl[sdata], with the target register's strobe line, framed by select_out.
- Also issues the single-cycle capture trigger on gpio_ctrl[trigger_line].
- Output drives adc_driver's gpio_ctrl and select_in inputs directly.

---
 rtl/rfsoc_cfg_serializer_pkg.sv | 41 ++++
 rtl/rfsoc_cfg_serializer_if.sv | 12 +
 rtl/rfsoc_cfg_serializer.sv | 180 ++++++++++++++++++
 tb/tb_rfsoc_cfg_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_cfg_serializer_pkg.sv
// Shared definitions for the rfsoc_config GPIO serial-configuration protocol:
// register width, gpio bit assignments, target codes and FSM state encoding.
package rfsoc_config;

  localparam int unsigned config_reg_width = 32;

  // gpio_ctrl bit assignments as seen by adc_driver
  localparam int unsigned sdata                   = 0;
  localparam int unsigned trigger_line            = 1;
  localparam int unsigned adc_num_cycle_count_clk = 2;
  localparam int unsigned adc_shift_val_clk       = 3;

  typedef enum logic [1:0] {
    TGT_RUN_CYCLES = 2'd0,
    TGT_SHIFT_VAL  = 2'd1
  } cfg_target_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    SEL_LEAD  = 3'd2,
    SETUP     = 3'd3,
    CLK_HI    = 3'd4,
    CLK_LO    = 3'd5,
    SEL_TRAIL = 3'd6
  } cfg_ser_state_t;

  // Codes 2 and 3 are reserved and must never produce serial activity
  function automatic logic tgt_is_valid(input logic [1:0] tgt);
    return (tgt == 2'd0) || (tgt == 2'd1);
  endfunction

  // Strobe line that clocks the selected register inside adc_driver
  function automatic int unsigned tgt_gpio_idx(input cfg_target_t tgt);
    case (tgt)
      TGT_SHIFT_VAL: return adc_shift_val_clk;
      default:       return adc_num_cycle_count_clk;
    endcase
  endfunction

endpackage

// File: rtl/rfsoc_cfg_serializer_if.sv
// Parallel register-write handshake between PL logic and the serializer.
interface rfsoc_cfg_serializer_if #(
  parameter int CONFIG_REG_WIDTH = 32
);
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [1:0]                  cfg_target;
  logic [CONFIG_REG_WIDTH-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_target, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_target, input cfg_data, output cfg_ready);
endinterface

// File: rtl/rfsoc_cfg_serializer.sv
// Transmitter for the rfsoc_config GPIO protocol: shifts a latched register
// value out LSB-first on the sdata line, clocking it with the target strobe,
// framed by select_out. Also issues the one-cycle capture trigger.
module rfsoc_cfg_serializer
  import rfsoc_config::*;
#(
  parameter int CONFIG_REG_WIDTH = config_reg_width,
  parameter int SETUP_CYC        = 2,
  parameter int HIGH_CYC         = 2,
  parameter int LOW_CYC          = 2,
  parameter int GPIO_WIDTH       = 16
) (
  input  logic                   ps_clk,
  input  logic                   rst,
  rfsoc_cfg_serializer_if.slave  cfg_if,
  input  logic                   trig_req,
  output logic [GPIO_WIDTH-1:0]  gpio_ctrl,
  output logic                   select_out,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   trig_dropped
);

  localparam int PH_MAX = (SETUP_CYC > HIGH_CYC) ?
                          ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC) :
                          ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
  localparam int BIT_W  = $clog2(CONFIG_REG_WIDTH);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  cfg_ser_state_t              state_q, state_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic [CONFIG_REG_WIDTH-1:0] data_q, data_d;
  cfg_target_t                 tgt_q, tgt_d;
  logic [GPIO_WIDTH-1:0]       gpio_q, gpio_d;
  logic                        select_q, select_d;
  logic                        ready_q, ready_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        dropped_q, dropped_d;

  assign gpio_ctrl        = gpio_q;
  assign select_out       = select_q;
  assign cfg_done         = done_q;
  assign cfg_err          = err_q;
  assign trig_dropped     = dropped_q;
  assign cfg_if.cfg_ready = ready_q;

  // Next-state/counter logic, then outputs decoded from the next state so they register in step
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    data_d    = data_q;
    tgt_d     = tgt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    dropped_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A trigger takes priority; a concurrent write stays pending until after TRIG
        if (trig_req) begin
          state_d = TRIG;
        end else if (cfg_if.cfg_valid && ready_q) begin
          if (tgt_is_valid(cfg_if.cfg_target)) begin
            state_d = SEL_LEAD;
            data_d  = cfg_if.cfg_data;
            tgt_d   = cfg_target_t'(cfg_if.cfg_target);
            bit_d   = '0;
            phase_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        state_d = IDLE;
      end
      SEL_LEAD: begin
        state_d = SETUP;
        bit_d   = '0;
        phase_d = '0;
      end
      SETUP: begin
        if (phase_q == PH_W'(SETUP_CYC - 1)) begin
          state_d = CLK_HI;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      CLK_HI: begin
        if (phase_q == PH_W'(HIGH_CYC - 1)) begin
          state_d = CLK_LO;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      CLK_LO: begin
        if (phase_q == PH_W'(LOW_CYC - 1)) begin
          phase_d = '0;
          if (bit_q == BIT_W'(CONFIG_REG_WIDTH - 1)) begin
            state_d = SEL_TRAIL;
          end else begin
            state_d = SETUP;
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      SEL_TRAIL: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (trig_req && (state_q != IDLE)) begin
      dropped_d = 1'b1;
    end else begin
      dropped_d = 1'b0;
    end

    gpio_d   = '0;
    select_d = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      IDLE:                ready_d = 1'b1;
      TRIG:                gpio_d[trigger_line] = 1'b1;
      SEL_LEAD, SEL_TRAIL: select_d = 1'b1;
      SETUP, CLK_LO: begin
        select_d      = 1'b1;
        gpio_d[sdata] = data_d[bit_d];
      end
      CLK_HI: begin
        select_d      = 1'b1;
        gpio_d[sdata] = data_d[bit_d];
        gpio_d        = gpio_d | (GPIO_WIDTH'(1'b1) << tgt_gpio_idx(tgt_d));
      end
      default:             select_d = 1'b0;
    endcase
  end

  // State, counters, latched write and all outputs; reset aborts any frame silently
  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      phase_q   <= '0;
      data_q    <= '0;
      tgt_q     <= TGT_RUN_CYCLES;
      gpio_q    <= '0;
      select_q  <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      tgt_q     <= tgt_d;
      gpio_q    <= gpio_d;
      select_q  <= select_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_rfsoc_cfg_serializer.sv
// Directed self-checking bench for rfsoc_cfg_serializer.
module tb_rfsoc_cfg_serializer;
  import rfsoc_config::*;

  logic        ps_clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig_req = 1'b0;
  logic [15:0] gpio_ctrl;
  logic        select_out, cfg_done, cfg_err, trig_dropped;

  int n_checks = 0;
  int n_errors = 0;

  rfsoc_cfg_serializer_if #(.CONFIG_REG_WIDTH(32)) cfg_bus ();

  rfsoc_cfg_serializer dut (
    .ps_clk       (ps_clk),
    .rst          (rst),
    .cfg_if       (cfg_bus),
    .trig_req     (trig_req),
    .gpio_ctrl    (gpio_ctrl),
    .select_out   (select_out),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .trig_dropped (trig_dropped)
  );

  always #5 ps_clk = ~ps_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_select(input string tag);
    int n = 0;
    while (select_out !== 1'b1 && n < 20) begin
      @(negedge ps_clk);
      n++;
    end
    check_val({tag, "_start"}, 32'(select_out), 32'd1);
  endtask

  // Entered at the negedge of the first frame cycle; returns at the first IDLE negedge
  task automatic monitor_frame(input string tag, input logic [1:0] tgt, input logic [31:0] data,
                               input logic [31:0] new_data, input bit inject_trig);
    int sel_len = 0, pulses = 0, bad_hi = 0, run = 0, oth_hi = 0;
    int sd_hi = 0, trig_hi = 0, drops = 0, dones = 0;
    logic [31:0] recon = '0;
    logic prev_st = 1'b0, st;
    int unsigned s_idx = (tgt == 2'd1) ? adc_shift_val_clk : adc_num_cycle_count_clk;
    int unsigned o_idx = (tgt == 2'd1) ? adc_num_cycle_count_clk : adc_shift_val_clk;
    while (select_out === 1'b1 && sel_len < 300) begin
      st = gpio_ctrl[s_idx];
      if (st && !prev_st) begin
        if (pulses < 32) recon[pulses] = gpio_ctrl[sdata];
        pulses++;
      end
      if (st) run++;
      else begin
        if (prev_st && run != 2) bad_hi++;
        run = 0;
      end
      prev_st = st;
      if (gpio_ctrl[o_idx]) oth_hi++;
      if (gpio_ctrl[sdata]) sd_hi++;
      if (gpio_ctrl[trigger_line]) trig_hi++;
      if (trig_dropped) drops++;
      if (cfg_done) dones++;
      if (inject_trig && sel_len == 30) trig_req = 1'b1;
      if (sel_len == 31) trig_req = 1'b0;
      if (sel_len == 50) cfg_bus.cfg_data = new_data;
      sel_len++;
      @(negedge ps_clk);
    end
    check_val({tag, "_sel_len"}, sel_len, 32'd194);
    check_val({tag, "_strobes"}, pulses, 32'd32);
    check_val({tag, "_hi_width_bad"}, bad_hi, 32'd0);
    check_val({tag, "_other_strobe"}, oth_hi, 32'd0);
    check_val({tag, "_data"}, recon, data);
    check_val({tag, "_sdata_hi_cyc"}, sd_hi, 32'($countones(data)) * 32'd6);
    check_val({tag, "_trig_line"}, trig_hi, 32'd0);
    check_val({tag, "_dropped"}, drops, inject_trig ? 32'd1 : 32'd0);
    check_val({tag, "_early_done"}, dones, 32'd0);
    check_val({tag, "_done"}, 32'(cfg_done), 32'd1);
    check_val({tag, "_idle_gpio"}, 32'({gpio_ctrl, select_out}), 32'd0);
  endtask

  task automatic send_frame(input string tag, input logic [1:0] tgt, input logic [31:0] data,
                            input logic [31:0] new_data, input bit inject_trig);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = tgt;
    cfg_bus.cfg_data   = data;
    @(negedge ps_clk);
    wait_select(tag);
    cfg_bus.cfg_valid = 1'b0;
    monitor_frame(tag, tgt, data, new_data, inject_trig);
  endtask

  initial begin
    int errs;
    int rises;
    int n;
    logic prev, cur;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_target = 2'd0;
    cfg_bus.cfg_data   = 32'd0;

    // Reset state and release
    repeat (10) @(negedge ps_clk);
    check_val("rst_outputs", 32'({gpio_ctrl, select_out, cfg_bus.cfg_ready, cfg_done, cfg_err, trig_dropped}), 32'd0);
    rst = 1'b1;
    @(negedge ps_clk);
    check_val("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_val("rst_gpio", 32'({gpio_ctrl, select_out}), 32'd0);

    // Plain writes to both targets, data changed mid-frame
    send_frame("t0_d4", 2'd0, 32'd4, 32'hDEAD_BEEF, 1'b0);
    @(negedge ps_clk);
    check_val("t0_done_pulse", 32'(cfg_done), 32'd0);
    send_frame("t1_d0", 2'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    @(negedge ps_clk);

    // Trigger together with a write: trigger first, write accepted after
    trig_req = 1'b1;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = 2'd0;
    cfg_bus.cfg_data   = 32'h0000_00A5;
    @(negedge ps_clk);
    trig_req = 1'b0;
    check_val("trig_line_on", 32'({gpio_ctrl[trigger_line], cfg_bus.cfg_ready, select_out}), 32'b100);
    @(negedge ps_clk);
    check_val("trig_line_off", 32'({gpio_ctrl[trigger_line], cfg_bus.cfg_ready, select_out}), 32'b010);
    @(negedge ps_clk);
    check_val("trig_then_frame", 32'(select_out), 32'd1);
    cfg_bus.cfg_valid = 1'b0;
    monitor_frame("trig_a5", 2'd0, 32'h0000_00A5, 32'd0, 1'b0);
    @(negedge ps_clk);

    // Trigger request during a frame is dropped
    send_frame("drop", 2'd0, 32'h1234_5678, 32'd0, 1'b1);
    @(negedge ps_clk);

    // Reserved target
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = 2'd3;
    cfg_bus.cfg_data   = 32'hFFFF_FFFF;
    @(negedge ps_clk);
    cfg_bus.cfg_valid = 1'b0;
    check_val("rsv_err", 32'(cfg_err), 32'd1);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (gpio_ctrl != 16'd0 || select_out) errs++;
      @(negedge ps_clk);
    end
    check_val("rsv_quiet", errs, 32'd0);
    check_val("rsv_err_clear", 32'(cfg_err), 32'd0);

    // Back-to-back frames with cfg_valid held
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = 2'd1;
    cfg_bus.cfg_data   = 32'h8000_0001;
    @(negedge ps_clk);
    wait_select("b2b0");
    monitor_frame("b2b0", 2'd1, 32'h8000_0001, 32'h0F0F_00F0, 1'b0);
    @(negedge ps_clk);
    check_val("b2b_gap1", 32'(select_out), 32'd1);
    monitor_frame("b2b1", 2'd1, 32'h0F0F_00F0, 32'h0000_003C, 1'b0);
    @(negedge ps_clk);
    check_val("b2b_gap2", 32'(select_out), 32'd1);
    cfg_bus.cfg_valid = 1'b0;
    monitor_frame("b2b2", 2'd1, 32'h0000_003C, 32'd0, 1'b0);
    @(negedge ps_clk);
    check_val("b2b_no_fourth", 32'(select_out), 32'd0);

    // Reset in the middle of bit 5
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = 2'd0;
    cfg_bus.cfg_data   = 32'hFFFF_FFFF;
    @(negedge ps_clk);
    wait_select("mid_rst");
    cfg_bus.cfg_valid = 1'b0;
    prev = 1'b0;
    rises = 0;
    n = 0;
    while (rises < 6 && n < 200) begin
      cur = gpio_ctrl[adc_num_cycle_count_clk];
      if (cur && !prev) rises++;
      prev = cur;
      if (rises < 6) begin
        @(negedge ps_clk);
        n++;
      end
    end
    check_val("mid_rst_reach_bit5", rises, 32'd6);
    rst = 1'b0;
    #1;
    check_val("mid_rst_outputs", 32'({gpio_ctrl, select_out, cfg_bus.cfg_ready, cfg_done}), 32'd0);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ps_clk);
      if (cfg_done) errs++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ps_clk);
      if (cfg_done || select_out) errs++;
    end
    check_val("mid_rst_no_done", errs, 32'd0);
    check_val("mid_rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
